trace_capture: RTL and testbench

Parametrised execution-trace buffer for the single-cycle processor top level. It replaces fixed per-register and per-signal test outputs with one triggered capture of every architectural side effect: register-file writes and dmem writes, each tagged with the PC. It sits beside the processor, snoops the processor↔regfile and processor↔dmem buses, and exposes a valid/ready read-out port for the bench or a debug host.

---
 rtl/trace_capture.sv | 140 ++++++++++++++
 tb/tb_trace_capture.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/trace_capture.sv
// Triggered execution-trace buffer: snoops regfile and dmem writes, tags each with the PC,
// and serves them oldest-first over a valid/ready port. Define TRACE_WRAP_EN for ring mode.
module trace_capture #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int DEPTH     = 64,
    localparam int ENTRY_W  = 2 + 2*ADDR_W + DATA_W,
    localparam int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 arm,
    input  logic                 stop,
    input  logic [ADDR_W-1:0]    trig_pc,
    input  logic [ADDR_W-1:0]    pc,
    input  logic                 ctrl_writeEnable,
    input  logic [REG_IDX_W-1:0] ctrl_writeReg,
    input  logic [DATA_W-1:0]    data_writeReg,
    input  logic                 wren,
    input  logic [ADDR_W-1:0]    address_dmem,
    input  logic [DATA_W-1:0]    data,
    input  logic                 rd_ready,
    output logic                 rd_valid,
    output logic [ENTRY_W-1:0]   rd_entry,
    output logic [1:0]           state,
    output logic [CNT_W-1:0]     count,
    output logic [15:0]          dropped
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAPTURE = 2'd2, S_DONE = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [15:0]        dropped_q, dropped_d;
    logic [ENTRY_W-1:0] buf_q [DEPTH];

    logic               reg_ev, mem_ev, recording, wr_en;
    logic [1:0]         drop_inc;
    logic [16:0]        drop_sum;
    logic [ENTRY_W-1:0] entry;

    assign reg_ev    = ctrl_writeEnable && (ctrl_writeReg != '0);
    assign mem_ev    = wren;
    assign recording = (state_q == S_CAPTURE) || ((state_q == S_ARMED) && (pc == trig_pc));

    // A mem write wins a same-cycle collision with a reg write.
    always_comb begin
        entry = '0;
        if (mem_ev)
            entry = {2'b10, pc, address_dmem, data};
        else if (reg_ev)
            entry = {2'b01, pc, ADDR_W'(ctrl_writeReg), data_writeReg};
    end

    assign rd_valid = (state_q == S_DONE) && (count_q != '0);
    assign rd_entry = rd_valid ? buf_q[rptr_q] : '0;
    assign state    = state_q;
    assign count    = count_q;
    assign dropped  = dropped_q;

    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        count_d   = count_q;
        dropped_d = dropped_q;
        wr_en     = 1'b0;
        drop_inc  = 2'd0;
        drop_sum  = '0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d   = S_ARMED;
                    wptr_d    = '0;
                    rptr_d    = '0;
                    count_d   = '0;
                    dropped_d = '0;
                end else if (rd_valid && rd_ready) begin
                    rptr_d  = rptr_q + 1'b1;
                    count_d = count_q - 1'b1;
                end
            end
            S_ARMED:   if (pc == trig_pc) state_d = S_CAPTURE;
            S_CAPTURE: if (stop) state_d = S_DONE;
            default:   state_d = S_IDLE;
        endcase

        if (recording && (reg_ev || mem_ev)) begin
            if (reg_ev && mem_ev)
                drop_inc = drop_inc + 2'd1;
            wr_en  = 1'b1;
            wptr_d = wptr_q + 1'b1;
`ifdef TRACE_WRAP_EN
            // Ring mode: overwrite the oldest entry, so the read side slides with the write side.
            if (count_q == FULL) begin
                rptr_d   = rptr_q + 1'b1;
                drop_inc = drop_inc + 2'd1;
            end else begin
                count_d = count_q + 1'b1;
            end
`else
            count_d = count_q + 1'b1;
            if (count_q == FULL - 1'b1)
                state_d = S_DONE;
`endif
        end

        if (drop_inc != 2'd0) begin
            drop_sum  = {1'b0, dropped_q} + 17'(drop_inc);
            dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            dropped_q <= dropped_d;
        end
    end

    // Storage is never reset; stale contents are masked by rd_valid.
    always_ff @(posedge clock) begin
        if (wr_en && !reset)
            buf_q[wptr_q] <= entry;
    end
endmodule

// File: tb/tb_trace_capture.sv
// Scoreboard bench for trace_capture at DEPTH=4; follows TRACE_WRAP_EN to pick full-buffer expectations.
module tb_trace_capture;
    localparam int AW = 12, DW = 32, RW = 5, DEP = 4;
    localparam int EW = 2 + 2*AW + DW;
    localparam int CW = $clog2(DEP) + 1;

    logic          clock = 1'b0;
    logic          reset, arm, stop, ctrl_writeEnable, wren, rd_ready, rd_valid;
    logic [AW-1:0] trig_pc, pc, address_dmem;
    logic [RW-1:0] ctrl_writeReg;
    logic [DW-1:0] data_writeReg, data;
    logic [EW-1:0] rd_entry;
    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [15:0]   dropped;

    logic [EW-1:0] sb [$];
    int compared = 0;
    int mismatched = 0;

    always #5 clock = ~clock;

    trace_capture #(.ADDR_W(AW), .DATA_W(DW), .REG_IDX_W(RW), .DEPTH(DEP)) dut (
        .clock(clock), .reset(reset), .arm(arm), .stop(stop), .trig_pc(trig_pc), .pc(pc),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .wren(wren), .address_dmem(address_dmem), .data(data), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_entry(rd_entry), .state(state), .count(count), .dropped(dropped)
    );

    function automatic logic [EW-1:0] mk(input logic [1:0] k, input logic [AW-1:0] p,
                                         input logic [AW-1:0] t, input logic [DW-1:0] v);
        return {k, p, t, v};
    endfunction

    // One clock of stimulus; sampling happens 1 time unit after the edge.
    task automatic cyc(input logic [AW-1:0] p, input logic we, input logic [RW-1:0] wr,
                       input logic [DW-1:0] wd, input logic mw, input logic [AW-1:0] ma,
                       input logic [DW-1:0] md, input logic a, input logic s);
        pc = p; ctrl_writeEnable = we; ctrl_writeReg = wr; data_writeReg = wd;
        wren = mw; address_dmem = ma; data = md; arm = a; stop = s;
        @(posedge clock); #1;
        arm = 1'b0; stop = 1'b0; ctrl_writeEnable = 1'b0; wren = 1'b0;
    endtask

    task automatic chk_status(input string nm, input logic [1:0] st, input logic [CW-1:0] cn,
                              input logic [15:0] dr);
        compared++;
        if (state !== st || count !== cn || dropped !== dr) begin
            mismatched++;
            $display("FAIL %s status: state=%0d count=%0d dropped=%0d, expected state=%0d count=%0d dropped=%0d",
                     nm, state, count, dropped, st, cn, dr);
        end
    endtask

    // Pops every scoreboard entry, one per cycle, then expects an empty buffer.
    task automatic drain(input string nm);
        rd_ready = 1'b1;
        while (sb.size() > 0) begin
            compared++;
            if (rd_valid !== 1'b1 || rd_entry !== sb[0]) begin
                mismatched++;
                $display("FAIL %s pop: valid=%b entry=%h, expected valid=1 entry=%h", nm, rd_valid, rd_entry, sb[0]);
            end
            void'(sb.pop_front());
            @(posedge clock); #1;
        end
        rd_ready = 1'b0;
        compared++;
        if (rd_valid !== 1'b0 || count !== '0) begin
            mismatched++;
            $display("FAIL %s empty: valid=%b count=%0d, expected valid=0 count=0", nm, rd_valid, count);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk_status("reset", 2'd0, '0, 16'd0);
        compared++;
        if (rd_valid !== 1'b0 || rd_entry !== '0) begin
            mismatched++;
            $display("FAIL reset rd: valid=%b entry=%h, expected 0/0", rd_valid, rd_entry);
        end
        reset = 1'b0;
    endtask

    task automatic test_trigger();
        trig_pc = 12'd4;
        cyc(12'h3FF, 0, 0, 0, 0, 0, 0, 1, 0);
        chk_status("trig_arm", 2'd1, '0, 16'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(12'(i), (i == 3 || i == 6), (i == 3) ? 5'd3 : 5'd5, (i == 3) ? 32'h11 : 32'h22,
                0, 0, 0, 0, (i == 8));
            if (i == 6) sb.push_back(mk(2'b01, 12'd6, 12'd5, 32'h22));
            if (i == 4) chk_status("trig_match", 2'd2, '0, 16'd0);
        end
        chk_status("trig_done", 2'd3, CW'(1), 16'd0);
        drain("trigger");
    endtask

    task automatic test_handshake();
        trig_pc = 12'h10;
        cyc(12'h3FF, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(12'h10 + 12'(i), 1, 5'(i + 1), 32'hA0 + 32'(i), 0, 0, 0, 0, 0);
            sb.push_back(mk(2'b01, 12'h10 + 12'(i), 12'(i + 1), 32'hA0 + 32'(i)));
        end
        cyc(12'h13, 0, 0, 0, 0, 0, 0, 0, 1);
        chk_status("hs_done", 2'd3, CW'(3), 16'd0);
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            compared++;
            if (rd_valid !== 1'b1 || rd_entry !== sb[0]) begin
                mismatched++;
                $display("FAIL hs_hold cycle %0d: valid=%b entry=%h, expected valid=1 entry=%h",
                         i, rd_valid, rd_entry, sb[0]);
            end
            @(posedge clock); #1;
        end
        drain("handshake");
    endtask

    task automatic test_simul();
        trig_pc = 12'h40;
        cyc(12'h3FF, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(12'h40, 1, 5'd7, 32'h77, 1, 12'h20, 32'hAB, 0, 0);
        sb.push_back(mk(2'b10, 12'h40, 12'h20, 32'hAB));
        cyc(12'h41, 1, 5'd0, 32'h99, 0, 0, 0, 0, 1);
        chk_status("simul", 2'd3, CW'(1), 16'd1);
        drain("simul");
    endtask

    task automatic test_full();
        trig_pc = 12'h80;
        cyc(12'h3FF, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(12'h80 + 12'(i), 1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0, 0, 0);
`ifdef TRACE_WRAP_EN
            sb.push_back(mk(2'b01, 12'h80 + 12'(i), 12'(i + 1), 32'h100 + 32'(i)));
            if (i == 3) chk_status("full_4th", 2'd2, CW'(4), 16'd0);
`else
            if (i < 4) sb.push_back(mk(2'b01, 12'h80 + 12'(i), 12'(i + 1), 32'h100 + 32'(i)));
            if (i == 3) chk_status("full_4th", 2'd3, CW'(4), 16'd0);
`endif
        end
`ifdef TRACE_WRAP_EN
        cyc(12'h86, 0, 0, 0, 0, 0, 0, 0, 1);
        void'(sb.pop_front());
        void'(sb.pop_front());
        chk_status("full_end", 2'd3, CW'(4), 16'd2);
`else
        chk_status("full_end", 2'd3, CW'(4), 16'd0);
`endif
        drain("full");
    endtask

    task automatic test_reset_mid();
        trig_pc = 12'h200;
        cyc(12'h3FF, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(12'h200, 1, 5'd1, 32'h1, 0, 0, 0, 0, 0);
        cyc(12'h201, 1, 5'd2, 32'h2, 0, 0, 0, 0, 0);
        chk_status("mid_pre", 2'd2, CW'(2), 16'd0);
        reset = 1'b1;
        cyc(12'h202, 1, 5'd3, 32'h3, 0, 0, 0, 1, 1);
        reset = 1'b0;
        chk_status("mid_reset", 2'd0, '0, 16'd0);
        compared++;
        if (rd_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset rd_valid: got %b, expected 0", rd_valid);
        end
        sb.delete();
        cyc(12'h3FF, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(12'h200, 1, 5'd4, 32'h44, 0, 0, 0, 0, 0);
        sb.push_back(mk(2'b01, 12'h200, 12'd4, 32'h44));
        cyc(12'h201, 0, 0, 0, 0, 0, 0, 0, 1);
        chk_status("mid_recapture", 2'd3, CW'(1), 16'd0);
        drain("reset_mid");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; arm = 1'b0; stop = 1'b0; trig_pc = '0; pc = '0;
        ctrl_writeEnable = 1'b0; ctrl_writeReg = '0; data_writeReg = '0;
        wren = 1'b0; address_dmem = '0; data = '0; rd_ready = 1'b0;
        test_reset();
        test_trigger();
        test_handshake();
        test_simul();
        test_full();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
